// File: rtl/fu_pkg.sv
// Shared definitions for the functional-unit set (multiplier, divider).
//   div_state_t        : divider FSM state encoding
//   DIV_WIDTH_DEFAULT  : default operand width, shared with multiplier benches
//   div_cnt_w()        : width of a counter that must hold the value 0..width
package fu_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_RUN,
        DIV_DONE
    } div_state_t;

    localparam int DIV_WIDTH_DEFAULT = 32;

    function automatic int div_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/divider_sequential_div_step.sv
// One restoring-division iteration, purely combinational.
// The partial remainder and dividend/quotient register are treated as one
// long register shifted left by one; the divisor is then trial-subtracted
// from the upper part.
// Ports:
//   i_rem     [WIDTH:0]   current partial remainder
//   i_quo_msb             bit shifted out of the dividend/quotient register
//   i_divisor [WIDTH-1:0] divisor
//   o_rem     [WIDTH:0]   partial remainder after this iteration
//   o_q_bit               quotient bit produced by this iteration
module div_step
    import fu_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic [WIDTH:0]   i_rem,
    input  logic             i_quo_msb,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH:0]   o_rem,
    output logic             o_q_bit
);

    logic [WIDTH+1:0] w_shifted;
    logic [WIDTH+1:0] w_trial;

    // One guard bit above the shifted remainder makes the borrow of the
    // subtraction appear as the sign bit of w_trial.
    assign w_shifted = {i_rem, i_quo_msb};
    assign w_trial   = w_shifted - {2'b00, i_divisor};

    assign o_q_bit = ~w_trial[WIDTH+1];
    assign o_rem   = o_q_bit ? w_trial[WIDTH:0] : w_shifted[WIDTH:0];

endmodule

// File: rtl/divider_sequential.sv
// Iterative unsigned divider: q = a / b, r = a % b, one quotient bit per clock.
// Handshake: start is accepted when the unit is not running; done pulses for
// one cycle when q/r hold the new result. q/r keep their value until the next
// result is written.
// Ports:
//   clk    clock, all state changes on posedge
//   reset  synchronous, active-high; aborts any operation in progress
//   start  operation request, accepted when busy=0
//   a, b   dividend / divisor, sampled only on an accepted start
//   busy   high while iterating; start is ignored then
//   done   one-cycle pulse, q/r valid from this cycle onward
//   q, r   quotient / remainder (b==0 gives q=all ones, r=a)
// Timing: start accepted at edge N -> WIDTH iteration edges (N+1..N+WIDTH),
// one DONE edge (N+WIDTH+1) that writes q/r and raises done.
// Divide by zero skips the iterations: DONE edge is N+1.
module divider_sequential
    import fu_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r
);

    localparam int CNT_W = div_cnt_w(WIDTH);

    div_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH:0]   w_rem_next;
    logic             w_q_bit;
    logic             w_accept;

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .i_rem    (r_rem),
        .i_quo_msb(r_quo[WIDTH-1]),
        .i_divisor(r_div),
        .o_rem    (w_rem_next),
        .o_q_bit  (w_q_bit)
    );

    // DONE accepts a new request just like IDLE, so back-to-back operations
    // lose no cycle.
    assign w_accept = start && (r_state != DIV_RUN);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= DIV_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_q     <= '0;
            r_r     <= '0;
        end else begin
            r_done <= 1'b0;

            case (r_state)
                DIV_IDLE: begin
                    r_state <= DIV_IDLE;
                end
                DIV_RUN: begin
                    r_rem <= w_rem_next;
                    r_quo <= {r_quo[WIDTH-2:0], w_q_bit};
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= DIV_DONE;
                        r_busy  <= 1'b0;
                    end
                end
                DIV_DONE: begin
                    // Results become visible only here, never mid-iteration.
                    r_q     <= r_quo;
                    r_r     <= r_rem[WIDTH-1:0];
                    r_done  <= 1'b1;
                    r_state <= DIV_IDLE;
                end
                default: begin
                    r_state <= DIV_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase

            // Placed after the case so a request in DONE overrides the return
            // to IDLE; the accumulators are reloaded in the same edge that
            // copies the finished result out of them.
            if (w_accept) begin
                r_div <= b;
                r_cnt <= CNT_W'(WIDTH);
                if (b == '0) begin
                    // Divide by zero: preload the defined result and skip RUN.
                    r_quo   <= '1;
                    r_rem   <= {1'b0, a};
                    r_state <= DIV_DONE;
                    r_busy  <= 1'b0;
                end else begin
                    r_quo   <= a;
                    r_rem   <= '0;
                    r_state <= DIV_RUN;
                    r_busy  <= 1'b1;
                end
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign q    = r_q;
    assign r    = r_r;

endmodule

// File: tb/tb_divider_sequential.sv
module tb_divider_sequential;

    localparam int W = 32;
    localparam int LAT = W + 1;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] q;
    logic [W-1:0] r;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
    } vec_t;

    vec_t vecs[13];

    divider_sequential #(
        .WIDTH(W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .a    (a),
        .b    (b),
        .busy (busy),
        .done (done),
        .q    (q),
        .r    (r)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Single request pulse, then wait for done and check latency, busy
    // profile, result, and that done drops after one cycle.
    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic [W-1:0] eq, input logic [W-1:0] er,
                          input string nm);
        int  k;
        int  elat;
        bit  busy_ok;
        elat    = (ib == '0) ? 1 : LAT;
        a       = ia;
        b       = ib;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        a       = ~ia;
        b       = ~ib;
        busy_ok = 1'b1;
        k       = 0;
        while (done !== 1'b1 && k < 200) begin
            if ((k < elat - 1) != (busy === 1'b1)) busy_ok = 1'b0;
            tick();
            k++;
        end
        chk({nm, "_latency"}, W'(k), W'(elat));
        chk({nm, "_busy"}, W'(busy_ok), W'(1));
        chk({nm, "_q"}, q, eq);
        chk({nm, "_r"}, r, er);
        tick();
        chk({nm, "_done_pulse"}, W'(done), W'(0));
        chk({nm, "_q_hold"}, q, eq);
    endtask

    initial begin
        int k;
        int done_cnt;
        int first_k;
        int second_k;
        logic [W-1:0] q1, r1, q2, r2;
        logic [W-1:0] ra, rb, eq, er;

        vecs[0]  = '{32'd100,        32'd7,          32'd14,         32'd2};
        vecs[1]  = '{32'h1234_5678,  32'h0,          32'hFFFF_FFFF,  32'h1234_5678};
        vecs[2]  = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'h0};
        vecs[3]  = '{32'd5,          32'd9,          32'd0,          32'd5};
        vecs[4]  = '{32'h8000_0000,  32'h8000_0001,  32'h0,          32'h8000_0000};
        vecs[5]  = '{32'd0,          32'd5,          32'd0,          32'd0};
        vecs[6]  = '{32'd0,          32'd0,          32'hFFFF_FFFF,  32'd0};
        vecs[7]  = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0};
        vecs[8]  = '{32'd1000,       32'd10,         32'd100,        32'd0};
        vecs[9]  = '{32'hFFFF_FFFF,  32'd2,          32'h7FFF_FFFF,  32'd1};
        vecs[10] = '{32'h1234_5678,  32'h1_0000,     32'h1234,       32'h5678};
        vecs[11] = '{32'd7,          32'd7,          32'd1,          32'd0};
        vecs[12] = '{32'h8000_0000,  32'd3,          32'h2AAA_AAAA,  32'd2};

        reset = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        tick();
        tick();
        chk("reset_busy", W'(busy), W'(0));
        chk("reset_done", W'(done), W'(0));
        chk("reset_q", q, '0);
        chk("reset_r", r, '0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, $sformatf("vec%0d", i));
        end

        // start held high for the whole op with wandering operands; the second
        // operation is picked up in the DONE-state cycle.
        a     = 32'd100;
        b     = 32'd7;
        start = 1'b1;
        tick();
        done_cnt = 0;
        first_k  = -1;
        second_k = -1;
        q1 = '0; r1 = '0; q2 = '0; r2 = '0;
        for (int i = 1; i <= 80; i++) begin
            if (i == LAT) begin
                a = 32'd200;
                b = 32'd9;
            end else begin
                a = $urandom;
                b = $urandom;
            end
            if (i == LAT + 1) start = 1'b0;
            tick();
            if (done === 1'b1) begin
                done_cnt++;
                if (first_k < 0) begin
                    first_k = i; q1 = q; r1 = r;
                end else if (second_k < 0) begin
                    second_k = i; q2 = q; r2 = r;
                end
            end
        end
        chk("hs_first_latency", W'(first_k), W'(LAT));
        chk("hs_first_q", q1, 32'd14);
        chk("hs_first_r", r1, 32'd2);
        chk("hs_second_latency", W'(second_k), W'(2 * LAT));
        chk("hs_second_q", q2, 32'd22);
        chk("hs_second_r", r2, 32'd2);
        chk("hs_done_pulses", W'(done_cnt), W'(2));

        // Reset during iteration 10.
        a     = 32'd1000;
        b     = 32'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_mid_busy", W'(busy), W'(0));
        chk("rst_mid_done", W'(done), W'(0));
        chk("rst_mid_q", q, '0);
        chk("rst_mid_r", r, '0);
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done === 1'b1) done_cnt++;
        end
        chk("rst_mid_no_done", W'(done_cnt), W'(0));
        run_op(32'd77, 32'd5, 32'd15, 32'd2, "after_rst");

        // Stepped operand sweep.
        ra = 32'h0;
        rb = 32'h0;
        for (int i = 0; i < 200; i++) begin
            ra = ra + 32'h2345_6789;
            rb = rb + 32'h3456_7891;
            if (i % 4 == 3) rb = rb >> (i % 29);
            if (rb == '0) begin
                eq = '1;
                er = ra;
            end else begin
                eq = ra / rb;
                er = ra % rb;
            end
            run_op(ra, rb, eq, er, $sformatf("step%0d", i));
        end
        run_op(32'hDEAD_BEEF, 32'h0, 32'hFFFF_FFFF, 32'hDEAD_BEEF, "div0_late");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
